// File: rtl/cam_pkg.sv
// Shared constants and types for the camera capture path: byte order,
// default frame size and the packer state encoding.
package cam_pkg;

    localparam bit HI_FIRST = 1'b1;
    localparam int CAM_W    = 160;
    localparam int CAM_H    = 120;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } cam_state_t;

    // Byte lane (0 = bits 7:0) that the idx-th byte of a pixel pair lands in.
    function automatic logic [1:0] byte_lane(input logic [1:0] idx);
        return HI_FIRST ? {idx[1], ~idx[0]} : idx;
    endfunction

endpackage

// File: rtl/cam_pixel_packer_if.sv
// Byte-in / word-out streaming port of the pixel packer: FIFO read stage on
// one side, valid/ready word port towards the frame buffer writer on the other.
interface cam_pixel_packer_if #(
    parameter int ADDR_W = 14
);
    logic              rd_en;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              word_valid;
    logic              word_ready;
    logic [31:0]       word_data;
    logic [ADDR_W-1:0] word_addr;

    modport master (
        output rd_en, word_valid, word_data, word_addr,
        input  byte_valid, byte_data, word_ready
    );

    modport slave (
        input  rd_en, word_valid, word_data, word_addr,
        output byte_valid, byte_data, word_ready
    );
endinterface

// File: rtl/cam_byte_accum.sv
// Four-byte assembly register: places each incoming byte into its RGB565 lane
// and pulses word_complete the cycle after the fourth byte lands.
module cam_byte_accum
    import cam_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0] byte_cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // a blocking = here would let later statements see this cycle's update.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word          <= '0;
            byte_cnt      <= '0;
            word_complete <= 1'b0;
        end else begin
            word_complete <= byte_en && (byte_cnt == 2'd3);
            if (byte_en) begin
                word[8*byte_lane(byte_cnt) +: 8] <= byte_data;
                byte_cnt                         <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/cam_pixel_packer.sv
// Packs the AL422 RGB565 byte stream into 32-bit pixel-pair words with a
// sequential address, one WIDTH x HEIGHT frame per start pulse.
module cam_pixel_packer
    import cam_pkg::*;
#(
    parameter int WIDTH  = CAM_W,
    parameter int HEIGHT = CAM_H,
    parameter int ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    cam_pixel_packer_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int                TOTAL_WORDS = WIDTH * HEIGHT / 2;
    localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(TOTAL_WORDS - 1);

    cam_state_t        state, state_n;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       word_data;
    logic [31:0]       acc_word;
    logic              word_valid;
    logic              rd_en;
    logic              acc_complete;
    logic              accept, hold, load, lose, begin_frame;

    assign accept      = word_valid && bus.word_ready;
    assign hold        = word_valid && !bus.word_ready;
    assign begin_frame = (state == IDLE) && start;
    // A completed word either takes the output register or, if that is still
    // held by the consumer, is dropped and flagged.
    assign load        = (state == READ) && acc_complete && !hold;
    assign lose        = (state == READ) && acc_complete && hold;

    cam_byte_accum u_accum (
        .clk           (clk),
        .reset         (reset),
        .clear         (begin_frame),
        .byte_en       (bus.byte_valid && (state == READ)),
        .byte_data     (bus.byte_data),
        .word          (acc_word),
        .word_complete (acc_complete)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n = state;
        busy    = (state != IDLE);
        done    = (state == DONE);
        case (state)
            IDLE:    if (start) state_n = READ;
            READ:    if (load && (word_cnt == LAST_WORD)) state_n = DRAIN;
            DRAIN:   if (accept) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_en      <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_addr  <= '0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_n;
            // Throttle the FIFO while an un-accepted word sits in the output.
            rd_en <= (state_n == READ) && !hold;
            if (begin_frame) begin
                word_cnt  <= '0;
                word_addr <= '0;
                overflow  <= 1'b0;
            end
            if (load) begin
                word_valid <= 1'b1;
                word_data  <= acc_word;
                word_addr  <= word_cnt;
                word_cnt   <= word_cnt + 1'b1;
            end else if (accept) begin
                word_valid <= 1'b0;
            end
            if (lose) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.rd_en      = rd_en;
    assign bus.word_valid = word_valid;
    assign bus.word_data  = word_data;
    assign bus.word_addr  = word_addr;

endmodule
